// File: rtl/float_alu_arbiter.sv
// float_alu_arbiter: round-robin front-end sharing one combinational FloatALU among NREQ requesters.
// Define FALU_ARB_OPCHECK_EN to reject opcodes 14/15 with resp_err instead of executing them.
module float_alu_arbiter #(
  parameter int NREQ = 4,
  parameter int ALU_LAT = 1,
  localparam int IW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [4*NREQ-1:0]  req_op,
  input  logic [64*NREQ-1:0] req_r,
  input  logic [64*NREQ-1:0] req_s,
  output logic [NREQ-1:0]    req_ready,
  output logic [3:0]         alu_op,
  output logic [63:0]        alu_r,
  output logic [63:0]        alu_s,
  input  logic [63:0]        alu_y,
  input  logic [5:0]         alu_status,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IW-1:0]      resp_id,
  output logic [63:0]        resp_y,
  output logic [5:0]         resp_status,
  output logic               resp_err,
  output logic               busy
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, w_gid, w_idx;
  logic [3:0] r_cnt;
  logic w_any, w_bad, w_acc;
  logic [3:0] w_op;
  logic [63:0] w_r, w_s;
  // Scan downward so the last hit is the first valid requester at or after r_ptr.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gid = w_idx;
      end
    end
  end
  assign w_acc = (r_state == S_IDLE) && w_any;
  assign req_ready = w_acc ? {{(NREQ-1){1'b0}}, 1'b1} << w_gid : '0;
  assign w_op = req_op[w_gid*4 +: 4];
  assign w_r = req_r[w_gid*64 +: 64];
  assign w_s = req_s[w_gid*64 +: 64];
`ifdef FALU_ARB_OPCHECK_EN
  assign w_bad = w_op[3:1] == 3'b111;
`else
  assign w_bad = 1'b0;
`endif
  assign resp_valid = r_state == S_RESP;
  assign busy = r_state != S_IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = w_bad ? S_RESP : S_EXEC;
      S_EXEC: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      alu_op <= 4'd12;
      alu_r <= '0;
      alu_s <= '0;
      resp_id <= '0;
      resp_y <= '0;
      resp_status <= '0;
      resp_err <= 1'b0;
    end else begin
      if (w_acc) begin
        resp_id <= w_gid;
        resp_err <= w_bad;
        if (w_bad) begin
          resp_y <= '0;
          resp_status <= '0;
        end else begin
          alu_op <= w_op;
          alu_r <= w_r;
          alu_s <= w_s;
          r_cnt <= 4'(ALU_LAT);
        end
      end
      if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          resp_y <= alu_y;
          resp_status <= alu_status;
        end
      end
      if (resp_valid && resp_ready) r_ptr <= (resp_id == IW'(NREQ - 1)) ? '0 : resp_id + 1'b1;
    end
  end
endmodule
